// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: requester count,
// FSM state encoding and the rotating-priority winner search.
package rr_arbiter4_pkg;

    localparam int unsigned NUM_REQ = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // First set request bit searching upward from ptr, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0]         ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + i[1:0];
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

endpackage

// File: rtl/grant_dec.sv
// Combinational 2-bit owner index to 4-bit one-hot grant decoder.
module grant_dec
    import rr_arbiter4_pkg::*;
(
    input  logic [1:0]         idx_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    // Binary index to one-hot grant vector
    always_comb begin
        onehot_o = 4'b0000;
        case (idx_i)
            2'd0:    onehot_o = 4'b0001;
            2'd1:    onehot_o = 4'b0010;
            2'd2:    onehot_o = 4'b0100;
            2'd3:    onehot_o = 4'b1000;
            default: onehot_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded hold time and a
// one-cycle GAP state after every release; all outputs are registered.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         gnt_id,
    output logic               busy,
    output logic               timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [1:0]         state_q,    state_d;
    logic [NUM_REQ-1:0] gnt_q,      gnt_d;
    logic [1:0]         gnt_id_q,   gnt_id_d;
    logic               busy_q,     busy_d;
    logic               timeout_q,  timeout_d;
    logic [1:0]         ptr_q,      ptr_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;

    logic [1:0]         winner_s;
    logic [NUM_REQ-1:0] winner_dec_s;
    logic               owner_req_s;
    logic               hold_exp_s;
    logic               release_s;

    assign winner_s    = rr_pick(req, ptr_q);
    assign owner_req_s = req[gnt_id_q];
    assign hold_exp_s  = (hold_cnt_q == HOLD_LAST);
    assign release_s   = done | ~owner_req_s | hold_exp_s;

    grant_dec u_grant_dec (
        .idx_i    (winner_s),
        .onehot_o (winner_dec_s)
    );

    // Next-state logic for the IDLE/OWN/GAP arbitration FSM
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    state_d    = ST_OWN;
                    gnt_id_d   = winner_s;
                    gnt_d      = winner_dec_s;
                    busy_d     = 1'b1;
                    hold_cnt_d = 8'd0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (release_s) begin
                    state_d   = ST_GAP;
                    gnt_d     = 4'b0000;
                    busy_d    = 1'b0;
                    ptr_d     = gnt_id_q + 2'd1;
                    // Only a pure hold-limit release counts as a timeout
                    timeout_d = hold_exp_s & ~done & owner_req_s;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 4'b0000;
            gnt_id_q   <= 2'd0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 15, giving the maximum consecutive cycles one grant is held (legal 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port req, input, 4, request per requester; bit k is requester k.
REQ-005 SHALL have port done, input, 1, release strobe from the current owner.
REQ-006 SHALL have port gnt, output, 4, one-hot grant, registered.
REQ-007 SHALL have port gnt_id, output, 2, binary index of the current owner, registered.
REQ-008 SHALL have port busy, output, 1, high exactly while gnt is non-zero.
REQ-009 SHALL have port timeout, output, 1, one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-010 SHALL implement FSM states IDLE, OWN and GAP.
REQ-011 SHALL move IDLE->OWN on the edge where req!=0, else stay in IDLE.
REQ-012 SHALL, on the IDLE->OWN edge, load gnt_id with the winner and gnt with the decode of the winner; latency is 1 cycle from sampled req to visible gnt.
REQ-013 SHALL choose the winner as the first set req bit searching upward from ptr, wrapping 3->0.
REQ-014 SHALL hold gnt and gnt_id constant throughout OWN, ignoring req changes of non-owners.
REQ-015 SHALL clear hold_cnt (8 bits) on entry to OWN and increment it each OWN cycle.
REQ-016 SHALL release in OWN when any of the following holds: done==1; req[gnt_id]==0; hold_cnt==MAX_HOLD-1.
REQ-017 SHALL, on release, move to GAP, clear gnt to 0, and set ptr=gnt_id+1 mod 4.
REQ-018 SHALL pulse timeout for the single GAP cycle only when the release cause was hold_cnt alone (done==0 and req[gnt_id]==1).
REQ-019 SHALL move GAP->IDLE unconditionally, giving exactly one dead cycle between grants.
REQ-020 SHALL ignore done outside OWN.
REQ-021 SHALL keep gnt one-hot or zero, with gnt==decode(gnt_id) whenever busy==1.
REQ-022 SHALL, with MAX_HOLD=1, grant for exactly 1 cycle, and SHALL flag timeout only per REQ-018.

Reset
REQ-023 SHALL, on a clock edge with rst_n==0, set state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0 and hold_cnt=0.
REQ-024 SHALL let reset override every other event, including reset asserted mid-OWN; no release bookkeeping (ptr update, timeout) occurs on that edge.
REQ-025 SHALL evaluate req on the first edge with rst_n==1, so a request held through reset is granted 1 cycle after deassertion.

Structure
REQ-026 SHALL place the state encoding (IDLE, OWN, GAP) and the requester count (4) in a shared package.
REQ-027 SHALL instantiate one sub-module, grant_dec, a combinational 2-bit index to 4-bit one-hot decoder feeding the gnt register.
REQ-028 SHALL have no combinational path from req or done to any output.

Verification
REQ-029 SHALL verify reset then req=1111 held -> grants 0,1,2,3,0 in order, each 15 cycles with timeout pulsed after each, and a 1-cycle gnt=0000 gap between grants.
REQ-030 SHALL verify req=0100 for 1 cycle then 0000 -> gnt=0100 for 1 cycle (released by req drop), then GAP, then IDLE; timeout stays 0.
REQ-031 SHALL verify requester 1 owns, done pulses in the 3rd OWN cycle while req=1011 -> next grant is requester 3, then 0 after 3 releases.
REQ-032 SHALL verify with MAX_HOLD=4 and req=0001 held -> gnt=0001 high for exactly 4 cycles, timeout=1 in the following cycle, and re-grant to 0 after the GAP.
REQ-033 SHALL verify rst_n=0 asserted in the 2nd OWN cycle of requester 2 -> next cycle gnt=0000, gnt_id=00, ptr=0; with req=1111 after release, requester 0 is granted first.
REQ-034 SHALL verify done pulsed in IDLE with req=0000 -> no state change and all outputs remain 0.
